// File: rtl/cmd_rec_pkg.sv
// Shared definitions for the command recognizer: the FSM state type, the
// keyword tables (one character per slot, first character in slot 0),
// keyword lengths and the verb/object index assignments.
package cmd_rec_pkg;

  typedef enum logic {
    WAIT_VERB = 1'b0,
    WAIT_OBJ  = 1'b1
  } state_t;

  localparam int KW_CHAR_W  = 8;
  localparam int KW_MAX_LEN = 8;

  // Slot 0 is the leftmost element, so a string literal padded with zeros
  // on the right reads naturally as the keyword.
  typedef logic [0:KW_MAX_LEN-1][KW_CHAR_W-1:0] kw_t;

  localparam int NUM_VERBS = 2;
  localparam int NUM_OBJS  = 3;

  localparam int VERB_OPEN  = 0;
  localparam int VERB_CLOSE = 1;

  localparam int OBJ_WINDOW = 0;
  localparam int OBJ_DOOR   = 1;
  localparam int OBJ_LIGHT  = 2;

  localparam int LEN_OPEN   = 4;
  localparam int LEN_CLOSE  = 5;
  localparam int LEN_WINDOW = 6;
  localparam int LEN_DOOR   = 4;
  localparam int LEN_LIGHT  = 5;

  localparam kw_t VERB_TABLE [NUM_VERBS] = '{
    VERB_OPEN:  kw_t'({"OPEN",  32'h0}),
    VERB_CLOSE: kw_t'({"CLOSE", 24'h0})
  };

  localparam kw_t OBJ_TABLE [NUM_OBJS] = '{
    OBJ_WINDOW: kw_t'({"WINDOW", 16'h0}),
    OBJ_DOOR:   kw_t'({"DOOR",   32'h0}),
    OBJ_LIGHT:  kw_t'({"LIGHT",  24'h0})
  };

  localparam int VERB_LEN [NUM_VERBS] = '{
    VERB_OPEN:  LEN_OPEN,
    VERB_CLOSE: LEN_CLOSE
  };

  localparam int OBJ_LEN [NUM_OBJS] = '{
    OBJ_WINDOW: LEN_WINDOW,
    OBJ_DOOR:   LEN_DOOR,
    OBJ_LIGHT:  LEN_LIGHT
  };

endpackage

// File: rtl/command_recognizer_matcher.sv
// Position tracker for one keyword. Each accepted character either advances
// the position, completes the keyword (o_match, position back to 0), or falls
// back to position 1 when the mismatching character is the keyword's first
// letter, otherwise to 0. Idle cycles leave the position untouched.
module keyword_matcher
  import cmd_rec_pkg::*;
#(
  parameter int  CHAR_W  = 8,
  parameter int  MAX_LEN = 8,
  parameter int  LEN     = 4,
  parameter kw_t KW      = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [CHAR_W-1:0] i_char,
  input  logic              i_clear,
  output logic              o_match
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [PW-1:0]     r_pos;
  logic [CHAR_W-1:0] w_expected;
  logic [CHAR_W-1:0] w_first;
  logic              w_hit;
  logic              w_last;

  assign w_expected = CHAR_W'(KW[r_pos]);
  assign w_first    = CHAR_W'(KW[0]);
  assign w_hit      = i_valid && (i_char == w_expected);
  assign w_last     = (r_pos == PW'(LEN - 1));
  assign o_match    = w_hit && w_last;

  // Position update; a clear from the recognizer overrides this character's advance
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_pos <= '0;
    end else if (i_valid) begin
      if (w_hit) begin
        r_pos <= w_last ? '0 : r_pos + 1'b1;
      end else begin
        r_pos <= (i_char == w_first) ? PW'(1) : '0;
      end
    end
  end

endmodule

// File: rtl/command_recognizer.sv
// Verb+object command recognizer over a character stream. A verb arms the
// recognizer, a following object completes the command. If no object arrives
// within OBJ_TIMEOUT accepted characters the pending verb expires.
// Optional feature: define CMD_REC_STATUS_EN to track per-object open/closed
// status in o_obj_state; otherwise o_obj_state is tied to 0.
module command_recognizer
  import cmd_rec_pkg::*;
#(
  parameter int CHAR_W      = 8,
  parameter int N_VERB      = 2,
  parameter int N_OBJ       = 3,
  parameter int MAX_LEN     = 8,
  parameter int OBJ_TIMEOUT = 16,
  localparam int VW = (N_VERB > 1) ? $clog2(N_VERB) : 1,
  localparam int OW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_char_valid,
  input  logic [CHAR_W-1:0] i_char,
  output logic              o_cmd_valid,
  output logic [VW-1:0]     o_cmd_verb,
  output logic [OW-1:0]     o_cmd_obj,
  output logic              o_timeout,
  output logic [N_OBJ-1:0]  o_obj_state
);

  localparam int TW = $clog2(OBJ_TIMEOUT + 1);

  state_t r_state;
  state_t w_next_state;

  logic [VW-1:0] r_verb;
  logic [TW-1:0] r_tcount;
  logic          r_cmd_valid;
  logic [VW-1:0] r_cmd_verb;
  logic [OW-1:0] r_cmd_obj;
  logic          r_timeout;

  logic [N_VERB-1:0] w_verb_match;
  logic [N_OBJ-1:0]  w_obj_match;
  logic              w_verb_hit;
  logic [VW-1:0]     w_verb_idx;
  logic              w_obj_hit;
  logic [OW-1:0]     w_obj_idx;
  logic              w_last_slot;

  logic w_fire_cmd;
  logic w_fire_timeout;
  logic w_latch_verb;
  logic w_clear_verbs;
  logic w_clear_objs;

  genvar g;
  generate
    for (g = 0; g < N_VERB; g++) begin : g_verb
      keyword_matcher #(
        .CHAR_W (CHAR_W),
        .MAX_LEN(MAX_LEN),
        .LEN    (VERB_LEN[g]),
        .KW     (VERB_TABLE[g])
      ) u_matcher (
        .clock  (clock),
        .reset  (reset),
        .i_valid(i_char_valid),
        .i_char (i_char),
        .i_clear(w_clear_verbs),
        .o_match(w_verb_match[g])
      );
    end
    for (g = 0; g < N_OBJ; g++) begin : g_obj
      keyword_matcher #(
        .CHAR_W (CHAR_W),
        .MAX_LEN(MAX_LEN),
        .LEN    (OBJ_LEN[g]),
        .KW     (OBJ_TABLE[g])
      ) u_matcher (
        .clock  (clock),
        .reset  (reset),
        .i_valid(i_char_valid),
        .i_char (i_char),
        .i_clear(w_clear_objs),
        .o_match(w_obj_match[g])
      );
    end
  endgenerate

  // Lowest-index priority among simultaneous verb and object matches
  always_comb begin
    w_verb_hit = 1'b0;
    w_verb_idx = '0;
    w_obj_hit  = 1'b0;
    w_obj_idx  = '0;
    for (int i = N_VERB - 1; i >= 0; i--) begin
      if (w_verb_match[i]) begin
        w_verb_hit = 1'b1;
        w_verb_idx = VW'(i);
      end
    end
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (w_obj_match[i]) begin
        w_obj_hit = 1'b1;
        w_obj_idx = OW'(i);
      end
    end
  end

  // True when the character being accepted is the last one a pending verb may wait for
  assign w_last_slot = i_char_valid && (r_tcount == TW'(OBJ_TIMEOUT - 1));

  // State register plus the registered outputs, verb latch and timeout count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= WAIT_VERB;
      r_verb      <= '0;
      r_tcount    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_verb  <= '0;
      r_cmd_obj   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_valid <= w_fire_cmd;
      r_timeout   <= w_fire_timeout;
      if (w_latch_verb) begin
        r_verb <= w_verb_idx;
      end
      if (w_fire_cmd) begin
        r_cmd_verb <= r_verb;
        r_cmd_obj  <= w_obj_idx;
      end
      if (w_latch_verb || w_fire_cmd || w_fire_timeout) begin
        r_tcount <= '0;
      end else if (r_state == WAIT_OBJ && i_char_valid) begin
        r_tcount <= r_tcount + 1'b1;
      end
    end
  end

  // Next state: a verb arms, an object match or an expired wait returns to idle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_VERB: if (w_verb_hit) w_next_state = WAIT_OBJ;
      WAIT_OBJ:  if (w_obj_hit || w_last_slot) w_next_state = WAIT_VERB;
      default:   w_next_state = WAIT_VERB;
    endcase
  end

  // Actions per state; object beats expiry, expiry beats a replacement verb
  always_comb begin
    w_fire_cmd     = 1'b0;
    w_fire_timeout = 1'b0;
    w_latch_verb   = 1'b0;
    w_clear_verbs  = 1'b0;
    w_clear_objs   = 1'b0;
    case (r_state)
      WAIT_VERB: begin
        if (w_verb_hit) begin
          w_latch_verb = 1'b1;
          w_clear_objs = 1'b1;
        end
      end
      WAIT_OBJ: begin
        if (w_obj_hit) begin
          w_fire_cmd    = 1'b1;
          w_clear_verbs = 1'b1;
          w_clear_objs  = 1'b1;
        end else if (w_last_slot) begin
          w_fire_timeout = 1'b1;
          w_clear_verbs  = 1'b1;
          w_clear_objs   = 1'b1;
        end else if (w_verb_hit) begin
          w_latch_verb = 1'b1;
          w_clear_objs = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_verb  = r_cmd_verb;
  assign o_cmd_obj   = r_cmd_obj;
  assign o_timeout   = r_timeout;

`ifdef CMD_REC_STATUS_EN
  logic [N_OBJ-1:0] r_obj_state;

  // Object status follows each completed command, updating with the pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_obj_state <= '0;
    end else if (w_fire_cmd) begin
      r_obj_state[w_obj_idx] <= (r_verb == VW'(VERB_OPEN));
    end
  end

  assign o_obj_state = r_obj_state;
`else
  assign o_obj_state = '0;
`endif

endmodule
